// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_driver req/ack port between N_REQ requesters.
// One frame per grant, with a watchdog that aborts a frame whose ack never arrives.
module spi_req_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DW       = 16,
    parameter int unsigned TOUT_CYC = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                syn_rst,
    input  logic [N_REQ-1:0]    s_req,
    input  logic [N_REQ*DW-1:0] s_din,
    output logic [N_REQ-1:0]    s_ack,
    output logic [DW-1:0]       s_dout,
    output logic                s_err,
    output logic                m_req,
    output logic [DW-1:0]       m_din,
    input  logic                m_ack,
    input  logic [DW-1:0]       m_dout,
    output logic                busy,
    output logic [2:0]          gnt_id,
    output logic                tout_err
);

    localparam int unsigned IW = 3;
    localparam int unsigned CW = $clog2(TOUT_CYC);
    localparam logic [CW-1:0] WD_LAST  = CW'(TOUT_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_BUSY = 3'b010;
    localparam logic [2:0] ST_REL  = 3'b100;

    logic [2:0]       state, state_nxt;
    logic [IW-1:0]    rr_ptr, rr_ptr_nxt;
    logic [CW-1:0]    wd_cnt, wd_cnt_nxt;
    logic [N_REQ-1:0] s_ack_nxt;
    logic [DW-1:0]    s_dout_nxt;
    logic             s_err_nxt;
    logic             m_req_nxt;
    logic [DW-1:0]    m_din_nxt;
    logic             busy_nxt;
    logic [IW-1:0]    gnt_id_nxt;
    logic             tout_err_nxt;

    logic             win_vld;
    logic [IW-1:0]    win_id;
    logic [DW-1:0]    win_din;
    logic [N_REQ-1:0] gnt_oh;

    // Round-robin search: first set request at or above rr_ptr, else wrap to below it
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!win_vld && s_req[j] && (IW'(j) >= rr_ptr)) begin
                win_vld = 1'b1;
                win_id  = IW'(j);
            end
        end
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (!win_vld && s_req[j] && (IW'(j) < rr_ptr)) begin
                win_vld = 1'b1;
                win_id  = IW'(j);
            end
        end
    end

    // Lane mux for the winner's frame and one-hot decode of the held grant
    always_comb begin
        win_din = '0;
        gnt_oh  = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            if (IW'(j) == win_id) begin
                win_din = s_din[j*DW +: DW];
            end
            gnt_oh[j] = (IW'(j) == gnt_id);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        wd_cnt_nxt   = wd_cnt;
        s_ack_nxt    = '0;
        s_err_nxt    = 1'b0;
        s_dout_nxt   = s_dout;
        m_req_nxt    = m_req;
        m_din_nxt    = m_din;
        gnt_id_nxt   = gnt_id;
        tout_err_nxt = tout_err;

        if (syn_rst) begin
            state_nxt    = ST_IDLE;
            rr_ptr_nxt   = '0;
            wd_cnt_nxt   = '0;
            s_dout_nxt   = '0;
            m_req_nxt    = 1'b0;
            m_din_nxt    = '0;
            gnt_id_nxt   = '0;
            tout_err_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        gnt_id_nxt = win_id;
                        m_din_nxt  = win_din;
                        m_req_nxt  = 1'b1;
                        rr_ptr_nxt = (win_id == LAST_IDX) ? '0 : win_id + IW'(1);
                        wd_cnt_nxt = '0;
                        state_nxt  = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (m_ack) begin
                        m_req_nxt  = 1'b0;
                        s_dout_nxt = m_dout;
                        s_ack_nxt  = gnt_oh;
                        state_nxt  = ST_REL;
                    end else if (wd_cnt == WD_LAST) begin
                        m_req_nxt    = 1'b0;
                        s_dout_nxt   = '0;
                        s_ack_nxt    = gnt_oh;
                        s_err_nxt    = 1'b1;
                        tout_err_nxt = 1'b1;
                        state_nxt    = ST_REL;
                    end else begin
                        wd_cnt_nxt = wd_cnt + CW'(1);
                    end
                end
                ST_REL: begin
                    m_req_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
                default: begin
                    m_req_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            wd_cnt   <= '0;
            s_ack    <= '0;
            s_dout   <= '0;
            s_err    <= 1'b0;
            m_req    <= 1'b0;
            m_din    <= '0;
            busy     <= 1'b0;
            gnt_id   <= '0;
            tout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            wd_cnt   <= wd_cnt_nxt;
            s_ack    <= s_ack_nxt;
            s_dout   <= s_dout_nxt;
            s_err    <= s_err_nxt;
            m_req    <= m_req_nxt;
            m_din    <= m_din_nxt;
            busy     <= busy_nxt;
            gnt_id   <= gnt_id_nxt;
            tout_err <= tout_err_nxt;
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Scoreboard bench for spi_req_arbiter: directed frames, a simple spi_driver slave model,
// and a monitor that checks every s_ack pulse against the expected-frame queue.
`timescale 1ns/1ps
module tb_spi_req_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned TOUT = 64;

    typedef struct packed {
        logic [3:0]  ack;
        logic [2:0]  gnt;
        logic [15:0] din;
        logic [15:0] dout;
        logic        err;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          syn_rst;
    logic [N-1:0]  s_req;
    logic [N*DW-1:0] s_din;
    logic [N-1:0]  s_ack;
    logic [DW-1:0] s_dout;
    logic          s_err;
    logic          m_req;
    logic [DW-1:0] m_din;
    logic          m_ack;
    logic [DW-1:0] m_dout;
    logic          busy;
    logic [2:0]    gnt_id;
    logic          tout_err;

    logic slv_ack;
    logic inj_ack;
    logic slave_on;
    int   ack_dly;
    int   rereq [N];

    exp_t        exp_q[$];
    logic [15:0] dout_tab[$];

    int total = 0;
    int bad = 0;
    int mon_total = 0;
    int mon_bad = 0;

    assign m_ack = slv_ack | inj_ack;

    always #5 clk = ~clk;

    spi_req_arbiter #(
        .N_REQ    (N),
        .DW       (DW),
        .TOUT_CYC (TOUT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .syn_rst  (syn_rst),
        .s_req    (s_req),
        .s_din    (s_din),
        .s_ack    (s_ack),
        .s_dout   (s_dout),
        .s_err    (s_err),
        .m_req    (m_req),
        .m_din    (m_din),
        .m_ack    (m_ack),
        .m_dout   (m_dout),
        .busy     (busy),
        .gnt_id   (gnt_id),
        .tout_err (tout_err)
    );

    // spi_driver model: acks ack_dly cycles after seeing m_req, returning the next table entry
    initial begin
        int hi_cnt;
        int sidx;
        hi_cnt  = 0;
        sidx    = 0;
        slv_ack = 1'b0;
        m_dout  = '0;
        forever begin
            @(posedge clk);
            #1;
            slv_ack = 1'b0;
            if (!m_req) begin
                hi_cnt = 0;
            end else if (slave_on) begin
                if (hi_cnt == ack_dly) begin
                    slv_ack = 1'b1;
                    m_dout  = (sidx < dout_tab.size()) ? dout_tab[sidx] : 16'hDEAD;
                    sidx++;
                end
                hi_cnt++;
            end
        end
    end

    // Monitor: every s_ack pulse must match the head of the expected queue
    always @(negedge clk) begin
        exp_t got;
        exp_t want;
        if (rst_n && (s_ack != '0)) begin
            got = {s_ack, gnt_id, m_din, s_dout, s_err};
            mon_total++;
            if (exp_q.size() == 0) begin
                mon_bad++;
                $display("FAIL unexpected_ack actual=%h required=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    mon_bad++;
                    $display("FAIL frame actual ack=%b gnt=%0d din=%h dout=%h err=%b required ack=%b gnt=%0d din=%h dout=%h err=%b",
                             got.ack, got.gnt, got.din, got.dout, got.err,
                             want.ack, want.gnt, want.din, want.dout, want.err);
                end
            end
            mon_total++;
            if (busy !== 1'b1) begin
                mon_bad++;
                $display("FAIL busy_in_release actual=%b required=1", busy);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic set_lane(input int i, input logic [15:0] v);
        s_din[i*DW +: DW] = v;
    endtask

    task automatic expect_frame(input logic [3:0] a, input logic [2:0] g, input logic [15:0] di,
                                input logic [15:0] dq, input logic e);
        exp_t x;
        x = {a, g, di, dq, e};
        exp_q.push_back(x);
    endtask

    task automatic wait_mreq(input string nm);
        int c;
        c = 0;
        while (!m_req && c < 100) begin
            cyc(1);
            c++;
        end
        total++;
        if (!m_req) begin
            bad++;
            $display("FAIL %s m_req actual=0 required=1 within 100 cycles", nm);
        end
    endtask

    // Requester behaviour: drop s_req on its ack unless a re-request is pending
    task automatic serve(input int n, input int budget);
        int got;
        int c;
        got = 0;
        c   = 0;
        while (got < n && c < budget) begin
            cyc(1);
            c++;
            if (s_ack != '0) begin
                got++;
                for (int i = 0; i < N; i++) begin
                    if (s_ack[i]) begin
                        if (rereq[i] > 0) rereq[i]--;
                        else s_req[i] = 1'b0;
                    end
                end
            end
        end
        total++;
        if (got < n) begin
            bad++;
            $display("FAIL serve_acks actual=%0d required=%0d", got, n);
        end
    endtask

    task automatic pulse_syn_rst();
        syn_rst = 1'b1;
        cyc(1);
        syn_rst = 1'b0;
    endtask

    initial begin
        int hi;
        rst_n    = 1'b0;
        syn_rst  = 1'b0;
        s_req    = '0;
        s_din    = '0;
        inj_ack  = 1'b0;
        slave_on = 1'b1;
        ack_dly  = 3;
        for (int i = 0; i < N; i++) rereq[i] = 0;

        // All four requesters held from reset: grants 0,1,2,3
        for (int i = 0; i < N; i++) set_lane(i, 16'hA000 + 16'(i));
        s_req = 4'b1111;
        dout_tab.push_back(16'h1111);
        dout_tab.push_back(16'h2222);
        dout_tab.push_back(16'h3333);
        dout_tab.push_back(16'h4444);
        expect_frame(4'b0001, 3'd0, 16'hA000, 16'h1111, 1'b0);
        expect_frame(4'b0010, 3'd1, 16'hA001, 16'h2222, 1'b0);
        expect_frame(4'b0100, 3'd2, 16'hA002, 16'h3333, 1'b0);
        expect_frame(4'b1000, 3'd3, 16'hA003, 16'h4444, 1'b0);
        cyc(3);
        chk("rst_s_ack", 32'(s_ack), 32'h0);
        chk("rst_s_dout", 32'(s_dout), 32'h0);
        chk("rst_s_err", 32'(s_err), 32'h0);
        chk("rst_m_req", 32'(m_req), 32'h0);
        chk("rst_m_din", 32'(m_din), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_tout_err", 32'(tout_err), 32'h0);
        rst_n = 1'b1;
        serve(4, 200);
        cyc(2);
        chk("t2_busy_after", 32'(busy), 32'h0);
        chk("t2_m_req_after", 32'(m_req), 32'h0);

        // Single request on lane 1, slow ack
        set_lane(1, 16'hA5C3);
        dout_tab.push_back(16'h1234);
        expect_frame(4'b0010, 3'd1, 16'hA5C3, 16'h1234, 1'b0);
        ack_dly = 20;
        s_req   = 4'b0010;
        cyc(1);
        chk("t1_m_req_latency", 32'(m_req), 32'h1);
        chk("t1_gnt_id", 32'(gnt_id), 32'h1);
        chk("t1_m_din", 32'(m_din), 32'hA5C3);
        chk("t1_busy", 32'(busy), 32'h1);
        serve(1, 100);
        cyc(3);
        chk("t1_s_dout_held", 32'(s_dout), 32'h1234);
        pulse_syn_rst();
        chk("syn_rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("syn_rst_s_dout", 32'(s_dout), 32'h0);

        // Requesters 0 and 3 re-request after each ack: 0,3,0,3
        set_lane(0, 16'h0B0B);
        set_lane(3, 16'h3C3C);
        ack_dly = 3;
        for (int k = 0; k < 4; k++) dout_tab.push_back(16'h5001 + 16'(k));
        expect_frame(4'b0001, 3'd0, 16'h0B0B, 16'h5001, 1'b0);
        expect_frame(4'b1000, 3'd3, 16'h3C3C, 16'h5002, 1'b0);
        expect_frame(4'b0001, 3'd0, 16'h0B0B, 16'h5003, 1'b0);
        expect_frame(4'b1000, 3'd3, 16'h3C3C, 16'h5004, 1'b0);
        rereq[0] = 1;
        rereq[3] = 1;
        s_req    = 4'b1001;
        serve(4, 400);
        cyc(2);

        // Watchdog: no ack ever arrives
        slave_on = 1'b0;
        set_lane(2, 16'h7E57);
        expect_frame(4'b0100, 3'd2, 16'h7E57, 16'h0000, 1'b1);
        s_req = 4'b0100;
        wait_mreq("t4");
        hi = 0;
        while (m_req && hi < 200) begin
            cyc(1);
            hi++;
        end
        s_req = 4'b0000;
        chk("t4_busy_cycles", 32'(hi), 32'd64);
        chk("t4_tout_err_set", 32'(tout_err), 32'h1);
        cyc(5);
        chk("t4_tout_err_sticky", 32'(tout_err), 32'h1);
        chk("t4_busy_idle", 32'(busy), 32'h0);
        pulse_syn_rst();
        chk("t4_tout_err_cleared", 32'(tout_err), 32'h0);
        slave_on = 1'b1;

        // m_ack in IDLE is ignored
        inj_ack = 1'b1;
        cyc(1);
        inj_ack = 1'b0;
        chk("t5_idle_ack_busy", 32'(busy), 32'h0);
        chk("t5_idle_ack_s_ack", 32'(s_ack), 32'h0);
        cyc(1);
        chk("t5_idle_ack_s_ack2", 32'(s_ack), 32'h0);
        chk("t5_idle_ack_m_req", 32'(m_req), 32'h0);

        // Requester 2 drops mid-BUSY, still gets its ack; m_ack in RELEASE ignored
        set_lane(2, 16'h2D2D);
        ack_dly = 10;
        dout_tab.push_back(16'h6006);
        expect_frame(4'b0100, 3'd2, 16'h2D2D, 16'h6006, 1'b0);
        s_req = 4'b0100;
        wait_mreq("t5");
        cyc(3);
        s_req = 4'b0000;
        chk("t5_m_req_held", 32'(m_req), 32'h1);
        serve(1, 100);
        inj_ack = 1'b1;
        cyc(1);
        inj_ack = 1'b0;
        chk("t5_rel_ack_busy", 32'(busy), 32'h0);
        cyc(1);
        chk("t5_rel_ack_s_ack", 32'(s_ack), 32'h0);
        chk("t5_rel_ack_busy2", 32'(busy), 32'h0);
        chk("t5_rel_ack_m_req", 32'(m_req), 32'h0);
        chk("t5_s_dout_held", 32'(s_dout), 32'h6006);

        // Async reset mid-BUSY, then arbitration restarts from requester 0
        set_lane(1, 16'h6666);
        ack_dly = 30;
        s_req   = 4'b0010;
        wait_mreq("t6");
        cyc(3);
        rst_n = 1'b0;
        s_req = 4'b0000;
        #1;
        chk("t6_async_m_req", 32'(m_req), 32'h0);
        chk("t6_async_busy", 32'(busy), 32'h0);
        chk("t6_async_gnt_id", 32'(gnt_id), 32'h0);
        cyc(3);
        rst_n = 1'b1;
        set_lane(0, 16'h0F0F);
        set_lane(3, 16'hF0F0);
        ack_dly = 3;
        dout_tab.push_back(16'h9009);
        dout_tab.push_back(16'h900A);
        expect_frame(4'b0001, 3'd0, 16'h0F0F, 16'h9009, 1'b0);
        expect_frame(4'b1000, 3'd3, 16'hF0F0, 16'h900A, 1'b0);
        s_req = 4'b1001;
        serve(2, 200);
        cyc(3);

        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        total = total + mon_total;
        bad   = bad + mon_bad;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
